parity_frame_rx: RTL
====================

# parity_frame_rx

Serial frame receiver that checks parity on the consuming end of a one-bit-per-clock serial link whose transmitter appends a running parity bit. It samples `x` every clock and detects a start bit. It shifts in `DATA_BITS` data bits, LSB first, then checks the parity bit and the stop bit. Each completed frame is presented as a parallel word with error flags. The block sits between the serial link and word-level logic and replaces ad-hoc parity FSMs on the receive side.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 1..16.
- `ODD`, default 0: 0 = even parity (data ones + parity bit must be even); 1 = odd parity.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`.
- `x`  in  1  serial line, one bit per clock; idles high.
- `data`  out  DATA_BITS  last received data word.
- `valid`  out  1  one-cycle pulse: `data`/flags updated with a new frame.
- `parity_err`  out  1  parity mismatch in the last frame.
- `frame_err`  out  1  stop bit of the last frame was 0.
- `err_cnt`  out  8  frames with any error since reset; saturates at 255.
- `busy`  out  1  high while a frame is in progress (state != IDLE).

## Operation
- Frame format: start bit (0), then `DATA_BITS` data bits LSB first, then the parity bit, then the stop bit (1). Total `DATA_BITS`+3 bits.
- FSM states and transitions:
  - IDLE: `x`=0 → DATA; otherwise stay in IDLE.
  - DATA: shift `x` into the MSB of the shift register (right shift) and increment the bit counter. After bit `DATA_BITS`-1 → PARITY.
  - PARITY: latch `x` into the running parity → STOP.
  - STOP: update outputs → IDLE.
- Running parity register: cleared on entry to DATA, XORed with every data bit and with the parity bit.
- Parity check: `parity_err` = running parity XOR `ODD`. For even mode, 1 means the total count of ones was odd.
- `frame_err` = NOT(`x` sampled in STOP).
- At the STOP edge:
  - `data` ← shift register, and `valid` ← 1.
  - `parity_err` and `frame_err` are loaded.
  - `err_cnt` increments if either flag is set and `err_cnt` < 255.
- `valid` asserts for every completed frame, including errored ones. The flags qualify the word.
- `data`, `parity_err` and `frame_err` hold their values until the next frame completes.
- `busy` is a Moore output decoded from state only.
- A stop bit of 0 completes the frame with `frame_err`=1. That 0 is not reinterpreted as a start bit.

## Timing
- Reset values: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `err_cnt`=0, `busy`=0, state=IDLE.
- Let the start bit be sampled at edge E0. Data bits are sampled at E1..E`DATA_BITS`, parity at E`DATA_BITS`+1, and stop at E`DATA_BITS`+2.
- `valid` is high for exactly the one cycle after the stop edge.
- Back-to-back frames: in the cycle `valid` is high, the FSM is in IDLE. A 0 on `x` there is accepted as the next start bit, so zero idle bits are needed between frames.
- `busy` is high from the cycle after E0 through the cycle ending at the stop edge.
- Reset asserted mid-frame aborts the frame: no `valid`, partial data discarded, outputs return to reset values on that edge.
- Reset in the same cycle as a stop bit: reset wins, and `valid` stays 0.
- `err_cnt` at 255 with a further errored frame: it stays at 255, and `valid` and the flags still update.

## Test plan
- Reset then idle: hold `x`=1 for 20 cycles. Required: `busy`=0, `valid`=0, `err_cnt`=0 throughout.
- Good frame (`DATA_BITS`=8, `ODD`=0): send 0xA5 as bits 0,1,0,1,0,0,1,0,1,0,1. Required: `valid` pulses for 1 cycle one cycle after the stop edge; `data`=0xA5; both flags 0; `err_cnt`=0.
- Parity error: send 0x01 with parity bit 0 (bits 0,1,0,0,0,0,0,0,0,0,1). Required: `data`=0x01, `parity_err`=1, `frame_err`=0, `err_cnt`=1.
- Frame error with back-to-back traffic: send 0x3C with stop=0, then immediately (no idle) a valid 0xFF frame.
  - Required for the first frame: `frame_err`=1, `data`=0x3C.
  - Required for the second frame: `valid` pulses again with `data`=0xFF, flags 0, `err_cnt`=1.
- Reset mid-frame: assert `reset` for 1 cycle after 4 data bits of 0x5A, then send 0x12. Required: no `valid` for the aborted frame; then `data`=0x12, flags 0.
- Saturation and odd mode (`ODD`=1): send 257 frames each with a parity error. Required: `err_cnt`=255 and stays there. A following 0x07 frame with parity bit 0 (total ones odd) then gives `parity_err`=0.

Source files
------------

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB first, running parity bit, stop bit.
// Each completed frame is presented as a parallel word with parity/framing flags and a saturating error count.
module parity_frame_rx #(
    parameter int DATA_BITS = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [7:0]           err_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [7:0]           ecnt_q, ecnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        par_d   = par_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            IDLE: begin
                if (!x) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            DATA: begin
                sr_d                = sr_q >> 1;
                sr_d[DATA_BITS-1]   = x;
                par_d               = par_q ^ x;
                cnt_d               = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_BITS - 1))
                    state_d = PARITY;
            end
            PARITY: begin
                par_d   = par_q ^ x;
                state_d = STOP;
            end
            STOP: begin
                // A 0 stop bit ends the frame here; it is never taken as the next start bit.
                data_d  = sr_q;
                valid_d = 1'b1;
                perr_d  = par_q ^ ODD;
                ferr_d  = ~x;
                if ((perr_d || ferr_d) && (ecnt_q != 8'hFF))
                    ecnt_d = ecnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign err_cnt    = ecnt_q;
    assign busy       = (state_q != IDLE);

endmodule
